// File: rtl/pc_sequencer.sv
// Fetch PC sequencer: increment / redirect / exception / eret, with stall and a one-entry pending redirect.
// Latency: every accepted source updates pc on the next clock; stall freezes pc and buffers a redirect.
// Optional macro PC_SEQ_ALIGN_CHECK_EN traps misaligned redirect/eret targets instead of masking them.
module pc_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [31:0] RESET_ADDR = 32'h0000_3000,
    parameter logic [31:0] EXC_ADDR   = 32'h0000_4180,
    parameter int unsigned INC        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_req,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             eret_req,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic [WIDTH-1:0] epc,
    output logic             pend,
    output logic             align_err
);

    localparam int unsigned      ALIGN_BITS = (INC > 1) ? $clog2(INC) : 0;
    localparam logic [WIDTH-1:0] LOW_MASK   = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [WIDTH-1:0] RST_PC     = WIDTH'(RESET_ADDR);
    localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_ADDR);
    localparam logic [WIDTH-1:0] STEP       = WIDTH'(INC);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] pc_n;
    logic [WIDTH-1:0] epc_r, epc_n;
    logic [WIDTH-1:0] tgt_r, tgt_n;
    logic             aerr_n;
    logic             load;
    logic [WIDTH-1:0] load_tgt;

    // pc is kept as an offset from RESET_ADDR in a 2-state register: a bit
    // variable starts at 0, so pc reads RESET_ADDR from time 0 in simulation.
    bit   [WIDTH-1:0] pc_x;

    assign pc     = pc_x ^ RST_PC;
    assign pc_inc = pc + STEP;
    assign epc    = epc_r;
    assign pend   = (state == HOLD);

    always_comb begin
        pc_n     = pc;
        epc_n    = epc_r;
        tgt_n    = tgt_r;
        state_n  = state;
        aerr_n   = 1'b0;
        load     = 1'b0;
        load_tgt = '0;

        if (exc_req) begin
            pc_n    = EXC_PC;
            epc_n   = exc_pc & ~LOW_MASK;
            tgt_n   = '0;
            state_n = RUN;
        end else if (eret_req) begin
            load     = 1'b1;
            load_tgt = epc_r;
            tgt_n    = '0;
            state_n  = RUN;
        end else if (br_valid) begin
            if (stall) begin
                tgt_n   = br_target;
                state_n = HOLD;
            end else begin
                load     = 1'b1;
                load_tgt = br_target;
                tgt_n    = '0;
                state_n  = RUN;
            end
        end else if (!stall) begin
            if (state == HOLD) begin
                load     = 1'b1;
                load_tgt = tgt_r;
                tgt_n    = '0;
                state_n  = RUN;
            end else begin
                pc_n = pc + STEP;
            end
        end

        if (load) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            if ((load_tgt & LOW_MASK) != '0) begin
                pc_n   = EXC_PC;
                epc_n  = load_tgt;
                aerr_n = 1'b1;
            end else begin
                pc_n = load_tgt;
            end
`else
            pc_n = load_tgt & ~LOW_MASK;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_x  <= '0;
            epc_r <= '0;
            tgt_r <= '0;
            state <= RUN;
        end else begin
            pc_x  <= pc_n ^ RST_PC;
            epc_r <= epc_n;
            tgt_r <= tgt_n;
            state <= state_n;
        end
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic aerr_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            aerr_r <= 1'b0;
        end else begin
            aerr_r <= aerr_n;
        end
    end

    assign align_err = aerr_r;
`else
    logic unused_aerr;

    assign unused_aerr = aerr_n;
    assign align_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: stimulus pushes expected post-edge state, a monitor pops and compares.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        exc_req = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        eret_req = 1'b0;
    logic [31:0] pc, pc_inc, epc;
    logic        pend, align_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
        logic        aerr;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    pc_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .br_valid  (br_valid),
        .br_target (br_target),
        .exc_req   (exc_req),
        .exc_pc    (exc_pc),
        .eret_req  (eret_req),
        .pc        (pc),
        .pc_inc    (pc_inc),
        .epc       (epc),
        .pend      (pend),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new state after every edge; compare it against the oldest expectation.
    initial begin
        int idx = 0;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                idx++;
                chk("pc", idx, pc, e.pc);
                chk("pc_inc", idx, pc_inc, e.pc + 32'd4);
                chk("epc", idx, epc, e.epc);
                chk("pend", idx, {31'd0, pend}, {31'd0, e.pend});
                chk("align_err", idx, {31'd0, align_err}, {31'd0, e.aerr});
            end
        end
    end

    task automatic step(input logic r, input logic st, input logic bv, input logic [31:0] bt,
                        input logic ex, input logic [31:0] ep, input logic er,
                        input logic [31:0] e_pc, input logic [31:0] e_epc,
                        input logic e_pend, input logic e_aerr);
        exp_t e;
        @(negedge clk);
        reset     = r;
        stall     = st;
        br_valid  = bv;
        br_target = bt;
        exc_req   = ex;
        exc_pc    = ep;
        eret_req  = er;
        e.pc   = e_pc;
        e.epc  = e_epc;
        e.pend = e_pend;
        e.aerr = e_aerr;
        q.push_back(e);
    endtask

    initial begin
        #1;
        chk("pc_time0", 0, pc, 32'h0000_3000);

        //    rst st bv target        ex exc_pc       er  exp_pc        exp_epc       pend aerr
        step(1, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3000, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3004, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3008, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_300C, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3010, 32'h0,        0, 0);
        step(0, 0, 1, 32'h0000_3400, 0, 32'h0,        0,  32'h0000_3400, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3404, 32'h0,        0, 0);
        // redirect raised during a 3-cycle stall is applied when stall drops
        step(0, 1, 1, 32'h0000_3800, 0, 32'h0,        0,  32'h0000_3404, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3404, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3404, 32'h0,        1, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3800, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3804, 32'h0,        0, 0);
        // newer buffered redirect overwrites older one
        step(0, 1, 1, 32'h0000_3800, 0, 32'h0,        0,  32'h0000_3804, 32'h0,        1, 0);
        step(0, 1, 1, 32'h0000_3900, 0, 32'h0,        0,  32'h0000_3804, 32'h0,        1, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3900, 32'h0,        0, 0);
        // live redirect on the unstall cycle beats the buffered one
        step(0, 1, 1, 32'h0000_3800, 0, 32'h0,        0,  32'h0000_3900, 32'h0,        1, 0);
        step(0, 0, 1, 32'h0000_3A00, 0, 32'h0,        0,  32'h0000_3A00, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3A04, 32'h0,        0, 0);
        // exception during stall with a pending redirect, then eret
        step(0, 1, 1, 32'h0000_3B00, 0, 32'h0,        0,  32'h0000_3A04, 32'h0,        1, 0);
        step(0, 1, 0, 32'h0,         1, 32'h0000_3204, 0, 32'h0000_4180, 32'h0000_3204, 0, 0);
        step(0, 1, 0, 32'h0,         0, 32'h0,        0,  32'h0000_4180, 32'h0000_3204, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_4184, 32'h0000_3204, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        1,  32'h0000_3204, 32'h0000_3204, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3208, 32'h0000_3204, 0, 0);
        // exc and eret together: exc wins; then eret under stall still acts
        step(0, 0, 0, 32'h0,         1, 32'h0000_3300, 1, 32'h0000_4180, 32'h0000_3300, 0, 0);
        step(0, 1, 0, 32'h0,         0, 32'h0,        1,  32'h0000_3300, 32'h0000_3300, 0, 0);
`ifdef PC_SEQ_ALIGN_CHECK_EN
        step(0, 0, 1, 32'h0000_3402, 0, 32'h0,        0,  32'h0000_4180, 32'h0000_3402, 0, 1);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_4184, 32'h0000_3402, 0, 0);
`else
        step(0, 0, 1, 32'h0000_3402, 0, 32'h0,        0,  32'h0000_3400, 32'h0000_3300, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3404, 32'h0000_3300, 0, 0);
`endif
        step(0, 0, 0, 32'h0,         1, 32'h0000_3207, 0, 32'h0000_4180, 32'h0000_3204, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_4184, 32'h0000_3204, 0, 0);
        // wrap modulo 2^32
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,        0,  32'hFFFF_FFFC, 32'h0000_3204, 0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_0000, 32'h0000_3204, 0, 0);
        // reset mid-HOLD drops the buffered redirect
        step(0, 1, 1, 32'h0000_3500, 0, 32'h0,        0,  32'h0000_0000, 32'h0000_3204, 1, 0);
        step(1, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3000, 32'h0,        0, 0);
        step(0, 0, 0, 32'h0,         0, 32'h0,        0,  32'h0000_3004, 32'h0,        0, 0);

        begin
            int budget = 20;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            #2;
            if (q.size() > 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL drain: %0d expectations left, required 0", q.size());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
